// File: rtl/mem_reg.sv
// ----------------------------------------------------------------------------
// mem_reg -- general-purpose register file with two combinational read ports
// and one synchronous write port.
//
// Register 0 is hardwired to zero. Addresses at or beyond p_REG_FILE_SIZE read
// as zero and ignore writes. Reads have no write bypass: a register written on
// a given edge shows its new value only after that edge.
//
// Ports:
//   i_clk        in   1               clock, rising edge
//   i_rst_n      in   1               asynchronous active-low reset
//   i_src1       in   p_REG_ADDR_LEN  read port 1 address
//   i_src2       in   p_REG_ADDR_LEN  read port 2 address
//   o_src1_data  out  p_WORD_LEN      read port 1 data
//   o_src2_data  out  p_WORD_LEN      read port 2 data
//   i_tgt        in   p_REG_ADDR_LEN  write address
//   i_tgt_data   in   p_WORD_LEN      write data
//   i_wr_en      in   1               write enable, active-high
//
// Optional build macro MEM_REG_DBG_PORT_EN adds a third read port:
//   i_dbg_addr   in   p_REG_ADDR_LEN  debug read address
//   o_dbg_data   out  p_WORD_LEN      debug read data
// ----------------------------------------------------------------------------
module mem_reg #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [p_REG_ADDR_LEN-1:0] i_src1,
  input  logic [p_REG_ADDR_LEN-1:0] i_src2,
  output logic [p_WORD_LEN-1:0]     o_src1_data,
  output logic [p_WORD_LEN-1:0]     o_src2_data,
  input  logic [p_REG_ADDR_LEN-1:0] i_tgt,
  input  logic [p_WORD_LEN-1:0]     i_tgt_data,
  input  logic                      i_wr_en
`ifdef MEM_REG_DBG_PORT_EN
  ,
  input  logic [p_REG_ADDR_LEN-1:0] i_dbg_addr,
  output logic [p_WORD_LEN-1:0]     o_dbg_data
`endif
);

  logic [p_WORD_LEN-1:0] regs [p_REG_FILE_SIZE];

  // An address is backed by storage only if it is nonzero and inside the file.
  function automatic logic addr_live(input logic [p_REG_ADDR_LEN-1:0] a);
    return (a != '0) && (int'(a) < p_REG_FILE_SIZE);
  endfunction

  // Reads are also gated by reset so outputs are zero for the whole time
  // reset is held, independent of the register contents.
  function automatic logic [p_WORD_LEN-1:0] rd_port(
    input logic [p_REG_ADDR_LEN-1:0] a,
    input logic                      rst_n
  );
    logic [p_WORD_LEN-1:0] d;
    d = '0;
    if (rst_n && addr_live(a)) d = regs[int'(a)];
    return d;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < p_REG_FILE_SIZE; i++) regs[i] <= '0;
    end else if (i_wr_en && addr_live(i_tgt)) begin
      regs[int'(i_tgt)] <= i_tgt_data;
    end
  end

  always_comb begin
    o_src1_data = rd_port(i_src1, i_rst_n);
    o_src2_data = rd_port(i_src2, i_rst_n);
  end

`ifdef MEM_REG_DBG_PORT_EN
  always_comb begin
    o_dbg_data = rd_port(i_dbg_addr, i_rst_n);
  end
`endif

endmodule

// File: tb/tb_mem_reg.sv
module tb_mem_reg;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] src1, src2, tgt;
  logic [W-1:0]  src1_data, src2_data, tgt_data;
  logic          wr_en;
`ifdef MEM_REG_DBG_PORT_EN
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
`endif

  int errors = 0;
  int checks = 0;

  // Reference contents: plain array, zero for anything never written.
  logic [W-1:0] model [2**AW];

  mem_reg #(.p_WORD_LEN(W), .p_REG_ADDR_LEN(AW), .p_REG_FILE_SIZE(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_src1     (src1),
    .i_src2     (src2),
    .o_src1_data(src1_data),
    .o_src2_data(src2_data),
    .i_tgt      (tgt),
    .i_tgt_data (tgt_data),
    .i_wr_en    (wr_en)
`ifdef MEM_REG_DBG_PORT_EN
    ,
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mdl_rd(input int a, input logic rn);
    if (!rn || a == 0 || a >= N) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
  endtask

  // Applies a write with read port 1 looking at the target; checks the old
  // value before the edge and the expected value after it.
  task automatic do_write(input int a, input logic [W-1:0] d, input logic en, input string tag);
    @(negedge clk);
    tgt = AW'(a); tgt_data = d; wr_en = en; src1 = AW'(a);
    #1 check({tag, "_pre"}, src1_data, mdl_rd(a, 1'b1));
    @(posedge clk);
    if (en && a != 0 && a < N) model[a] = d;
    #1 check({tag, "_post"}, src1_data, mdl_rd(a, 1'b1));
    wr_en = 1'b0;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; wr_en = 1'b0; tgt = '0; tgt_data = '0; src1 = '0; src2 = '0;
`ifdef MEM_REG_DBG_PORT_EN
    dbg_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1 src1 = 3'd5; src2 = 3'd7;
    #1 check("rst_src1", src1_data, '0);
    check("rst_src2", src2_data, '0);
    @(negedge clk); rst_n = 1'b1;

    // Populate some registers, then assert reset asynchronously mid-cycle.
    do_write(3, 16'hA5A5, 1'b1, "pre_r3");
    do_write(7, 16'h0F0F, 1'b1, "pre_r7");
    @(negedge clk); src1 = 3'd3; src2 = 3'd7;
    #2 rst_n = 1'b0;
    #1 check("async_src1", src1_data, '0);
    check("async_src2", src2_data, '0);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    for (int a = 1; a < 8; a++) begin
      src1 = AW'(a); src2 = AW'(8 - a);
      #1 check($sformatf("post_rst_r%0d", a), src1_data, '0);
      check($sformatf("post_rst2_r%0d", 8 - a), src2_data, '0);
    end

    // Write/read, no bypass, write enable off.
    do_write(3, 16'hBEEF, 1'b1, "wr_r3");
    do_write(3, 16'h1234, 1'b0, "nowr_r3");
    check("r3_kept", src1_data, 16'hBEEF);

`ifdef MEM_REG_DBG_PORT_EN
    dbg_addr = 3'd3;
    #1 check("dbg_r3", dbg_data, 16'hBEEF);
    dbg_addr = 3'd0;
    #1 check("dbg_r0", dbg_data, '0);
`endif

    // Register 0 is hardwired.
    do_write(0, 16'hFFFF, 1'b1, "wr_r0");
    src1 = '0; src2 = '0;
    #1 check("r0_src1", src1_data, 16'h0000);
    check("r0_src2", src2_data, 16'h0000);

    // Dual read ports.
    do_write(5, 16'h00AA, 1'b1, "wr_r5");
    do_write(6, 16'h5500, 1'b1, "wr_r6");
    src1 = 3'd5; src2 = 3'd6;
    #1 check("dual_src1", src1_data, 16'h00AA);
    check("dual_src2", src2_data, 16'h5500);
    src1 = 3'd6;
    #1 check("same_src1", src1_data, 16'h5500);
    check("same_src2", src2_data, 16'h5500);

    // Reset wins over a simultaneous write.
    do_write(2, 16'h7777, 1'b1, "wr_r2");
    @(negedge clk);
    tgt = 3'd2; tgt_data = 16'h1111; wr_en = 1'b1; src1 = 3'd2; rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1 check("rstwr_during", src1_data, '0);
    @(negedge clk); wr_en = 1'b0; rst_n = 1'b1;
    #1 check("rstwr_after", src1_data, '0);

    // First write after reset release lands on the next edge.
    do_write(4, 16'h4242, 1'b1, "first_after_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int a1, a2, at;
      logic [W-1:0] d;
      logic en;
      @(negedge clk);
      at = $urandom_range(0, 7); a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7);
      d = W'($urandom); en = 1'($urandom);
      tgt = AW'(at); tgt_data = d; wr_en = en; src1 = AW'(a1); src2 = AW'(a2);
`ifdef MEM_REG_DBG_PORT_EN
      dbg_addr = AW'(at);
`endif
      #1 check("rnd_src1", src1_data, mdl_rd(a1, 1'b1));
      check("rnd_src2", src2_data, mdl_rd(a2, 1'b1));
`ifdef MEM_REG_DBG_PORT_EN
      check("rnd_dbg", dbg_data, mdl_rd(at, 1'b1));
`endif
      @(posedge clk);
      if (en && at != 0 && at < N) model[at] = d;
      #1 check("rnd_post1", src1_data, mdl_rd(a1, 1'b1));
      check("rnd_post2", src2_data, mdl_rd(a2, 1'b1));
    end
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_reg.md
MEM_REG -- requirements
Module: mem_reg

Interface
REQ-001 Parameter p_WORD_LEN, default 16, data word width in bits.
REQ-002 Parameter p_REG_ADDR_LEN, default 3, register address width in bits.
REQ-003 Parameter p_REG_FILE_SIZE, default 8, number of registers; SHALL be <= 2**p_REG_ADDR_LEN.
REQ-004 i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_src1  input  p_REG_ADDR_LEN  read port 1 address.
REQ-007 i_src2  input  p_REG_ADDR_LEN  read port 2 address.
REQ-008 o_src1_data  output  p_WORD_LEN  read port 1 data.
REQ-009 o_src2_data  output  p_WORD_LEN  read port 2 data.
REQ-010 i_tgt  input  p_REG_ADDR_LEN  write port address.
REQ-011 i_tgt_data  input  p_WORD_LEN  write port data.
REQ-012 i_wr_en  input  1  write enable, active-high.

Function
REQ-013 Reads SHALL be purely combinational: o_srcN_data = reg[i_srcN] in the same cycle, no clock latency.
REQ-014 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-015 On rising i_clk with i_rst_n=1, i_wr_en=1, i_tgt != 0, reg[i_tgt] SHALL take i_tgt_data.
REQ-016 With i_wr_en=0, no register SHALL change.
REQ-017 No write-to-read bypass: a read of i_tgt during the write cycle SHALL return the old value; the new value SHALL appear after the edge.
REQ-018 Both read ports SHALL be independent; same address on both SHALL return identical data.
REQ-019 Addresses >= p_REG_FILE_SIZE SHALL read 0; writes to them SHALL be ignored.
REQ-020 Data SHALL be stored at full p_WORD_LEN width with no truncation or sign handling.

Reset
REQ-021 i_rst_n=0 SHALL clear all registers to 0 immediately, without waiting for a clock edge.
REQ-022 While i_rst_n=0, writes SHALL be ignored and both read ports SHALL output 0.
REQ-023 Reset asserted in the same cycle as a write SHALL win; the register SHALL remain 0.
REQ-024 After i_rst_n rises, the first write SHALL take effect on the next rising i_clk edge.

Configuration
REQ-025 Macro MEM_REG_DBG_PORT_EN: when defined, add input i_dbg_addr (p_REG_ADDR_LEN) and output o_dbg_data (p_WORD_LEN).
REQ-026 The debug port SHALL be a third combinational read port with the same rules as REQ-013, REQ-014, REQ-019 and REQ-022.
REQ-027 When the macro is undefined, these ports SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: i_rst_n=0 asynchronously mid-cycle -> all reads 0 at once; after release, read r1..r7 -> 0.
REQ-029 Write/read: write r3=0xBEEF with i_wr_en=1 -> o_src1_data=0xBEEF after the edge, not before; with i_wr_en=0, write 0x1234 to r3 -> r3 stays 0xBEEF.
REQ-030 R0: write 0xFFFF to address 0 -> i_src1=0 and i_src2=0 both read 0x0000.
REQ-031 Dual read: r5=0x00AA, r6=0x5500; src1=5, src2=6 -> 0x00AA/0x5500; src1=src2=6 -> both 0x5500.
REQ-032 Reset vs write: r2=0x7777, then i_rst_n=0 during a write of 0x1111 to r2 -> r2 reads 0x0000.
REQ-033 With MEM_REG_DBG_PORT_EN defined: i_dbg_addr=3 after REQ-029 -> o_dbg_data=0xBEEF; i_dbg_addr=0 -> 0x0000.
